// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, types and helpers.
package sha256_pkg;

   localparam int unsigned WordWidth  = 32;
   localparam int unsigned BlockWidth = 512;
   localparam int unsigned WinDepth   = 16;
   localparam int unsigned NumRounds  = 64;
   localparam int unsigned IdxWidth   = 6;

   typedef logic [WordWidth-1:0] word_t;

   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumRounds - 1);

   // Small sigma amounts (message schedule)
   localparam int unsigned S0Rot0 = 7;
   localparam int unsigned S0Rot1 = 18;
   localparam int unsigned S0Shr  = 3;
   localparam int unsigned S1Rot0 = 17;
   localparam int unsigned S1Rot1 = 19;
   localparam int unsigned S1Shr  = 10;

   // Big sigma amounts (compression rounds; third term is a rotate)
   localparam int unsigned B0Rot0 = 2;
   localparam int unsigned B0Rot1 = 13;
   localparam int unsigned B0Rot2 = 22;
   localparam int unsigned B1Rot0 = 6;
   localparam int unsigned B1Rot1 = 11;
   localparam int unsigned B1Rot2 = 25;

   typedef enum logic {
      StIdle,
      StStream
   } sched_state_e;

   // 32-bit circular right rotate
   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (WordWidth - n));
   endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 sigma pair. Defaults give the small sigmas s0/s1; clearing
// the Shift* flags and passing the big-sigma amounts turns the third term into a rotate.
module sha256_sigma
   import sha256_pkg::*;
#(
   parameter int unsigned Rot0A  = S0Rot0,
   parameter int unsigned Rot0B  = S0Rot1,
   parameter int unsigned Term0C = S0Shr,
   parameter bit          Shift0 = 1'b1,
   parameter int unsigned Rot1A  = S1Rot0,
   parameter int unsigned Rot1B  = S1Rot1,
   parameter int unsigned Term1C = S1Shr,
   parameter bit          Shift1 = 1'b1
) (
   input  word_t x,
   output word_t s0,
   output word_t s1
);

   word_t term0_c;
   word_t term1_c;

   assign term0_c = Shift0 ? (x >> Term0C) : rotr(x, Term0C);
   assign term1_c = Shift1 ? (x >> Term1C) : rotr(x, Term1C);

   assign s0 = rotr(x, Rot0A) ^ rotr(x, Rot0B) ^ term0_c;
   assign s1 = rotr(x, Rot1A) ^ rotr(x, Rot1B) ^ term1_c;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: takes one 512-bit block and streams W[0..63] using a
// 16-word sliding window that expands W[16..63] on the fly.
// Optional feature: define SHA256_SCHED_ABORT_EN to add the abort input.
module sha256_msg_schedule
   import sha256_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  blk_valid,
   output logic                  blk_ready,
   input  logic [BlockWidth-1:0] blk_data,
   output logic                  w_valid,
   input  logic                  w_ready,
   output logic [WordWidth-1:0]  w_data,
   output logic [IdxWidth-1:0]   w_idx,
   output logic                  w_last
`ifdef SHA256_SCHED_ABORT_EN
   ,
   input  logic                  abort
`endif
);

   sched_state_e          state_q, state_d;
   logic [IdxWidth-1:0]   t_q, t_d;
   word_t                 win_q [WinDepth];
   word_t                 win_d [WinDepth];

   logic  abort_req;
   logic  blk_hs;
   logic  w_hs;
   word_t s0_lo;
   word_t s1_hi;
   word_t unused_s1_lo;
   word_t unused_s0_hi;
   word_t new_word;

`ifdef SHA256_SCHED_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // s0 of W[t+1]
   sha256_sigma u_sigma_lo (
      .x  (win_q[1]),
      .s0 (s0_lo),
      .s1 (unused_s1_lo)
   );

   // s1 of W[t+14]
   sha256_sigma u_sigma_hi (
      .x  (win_q[WinDepth-2]),
      .s0 (unused_s0_hi),
      .s1 (s1_hi)
   );

   // W[t+16]; wraps modulo 2^32
   assign new_word = s1_hi + win_q[9] + s0_lo + win_q[0];

   // All w_* outputs come straight from registers
   assign blk_ready = (state_q == StIdle) && !abort_req;
   assign w_valid   = (state_q == StStream);
   assign w_data    = win_q[0];
   assign w_idx     = t_q;
   assign w_last    = w_valid && (t_q == LastIdx);

   assign blk_hs = blk_valid && blk_ready;
   assign w_hs   = w_valid && w_ready;

   // Next-state: block load, window shift on word handshake, abort return
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      win_d   = win_q;
      unique case (state_q)
         StIdle: begin
            if (blk_hs) begin
               for (int i = 0; i < WinDepth; i++) begin
                  win_d[i] = blk_data[WordWidth*(WinDepth-1-i) +: WordWidth];
               end
               t_d     = '0;
               state_d = StStream;
            end
         end
         StStream: begin
            if (abort_req) begin
               // Abort wins over a coincident word handshake
               t_d     = '0;
               state_d = StIdle;
            end else if (w_hs) begin
               for (int i = 0; i < WinDepth - 1; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[WinDepth-1] = new_word;
               t_d = t_q + 1'b1;
               if (t_q == LastIdx) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, round index and window registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         t_q     <= '0;
         win_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         win_q   <= win_d;
      end
   end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule; abort scenario runs when SHA256_SCHED_ABORT_EN is set.
module tb_sha256_msg_schedule;

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         w_valid;
   logic         w_ready;
   logic [31:0]  w_data;
   logic [5:0]   w_idx;
   logic         w_last;
`ifdef SHA256_SCHED_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0]  exp_w [2][64];
   logic [511:0] blk_a;
   logic [511:0] blk_b;

   sha256_msg_schedule dut (
      .clk       (clk),
      .rst       (rst),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .w_valid   (w_valid),
      .w_ready   (w_ready),
      .w_data    (w_data),
      .w_idx     (w_idx),
      .w_last    (w_last)
`ifdef SHA256_SCHED_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ {10'b0, x[31:10]};
   endfunction

   // Textbook full 64-word expansion
   task automatic expand(input int k, input logic [511:0] blk);
      logic [31:0] w [64];
      for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++) w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
      for (int t = 0; t < 64; t++) exp_w[k][t] = w[t];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      blk_valid = 1'b0;
      w_ready = 1'b0;
      blk_data = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({blk_ready, w_valid, w_data, w_idx, w_last} !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_active: got rdy=%b val=%b data=%h idx=%0d last=%b, want 1 0 0 0 0",
                  blk_ready, w_valid, w_data, w_idx, w_last);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({blk_ready, w_valid, w_data, w_idx, w_last} !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: got rdy=%b val=%b data=%h idx=%0d last=%b, want 1 0 0 0 0",
                  blk_ready, w_valid, w_data, w_idx, w_last);
      end
   endtask

   task automatic test_abc();
      blk_data = blk_a;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      checks++;
      if (blk_ready !== 1'b1) begin
         errors++;
         $display("FAIL abc_blk_ready: got %b want 1", blk_ready);
      end
      @(negedge clk);
      blk_valid = 1'b0;
      for (int t = 0; t < 64; t++) begin
         checks++;
         if ({w_valid, blk_ready, w_idx, w_data, w_last} !==
             {1'b1, 1'b0, 6'(t), exp_w[0][t], t == 63}) begin
            errors++;
            $display("FAIL abc_word t=%0d: got val=%b rdy=%b idx=%0d data=%h last=%b, want 1 0 %0d %h %b",
                     t, w_valid, blk_ready, w_idx, w_data, w_last, t, exp_w[0][t], t == 63);
         end
         if (t == 16) begin
            checks++;
            if (w_data !== 32'h61626380) begin
               errors++;
               $display("FAIL abc_w16: got %h want 61626380", w_data);
            end
         end
         if (t == 17) begin
            checks++;
            if (w_data !== 32'h000f0000) begin
               errors++;
               $display("FAIL abc_w17: got %h want 000f0000", w_data);
            end
         end
         @(negedge clk);
      end
      checks++;
      if ({blk_ready, w_valid, w_last} !== 3'b100) begin
         errors++;
         $display("FAIL abc_done: got rdy=%b val=%b last=%b, want 1 0 0", blk_ready, w_valid, w_last);
      end
   endtask

   task automatic test_backpressure();
      int  t;
      int  held;
      int  cyc;
      logic rdy;
      blk_data = blk_a;
      blk_valid = 1'b1;
      w_ready = 1'b0;
      @(negedge clk);
      blk_valid = 1'b0;
      t = 0;
      held = 0;
      cyc = 0;
      while (t < 64 && cyc < 1000) begin
         checks++;
         if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 6'(t), exp_w[0][t], t == 63}) begin
            errors++;
            $display("FAIL bp_word t=%0d cyc=%0d: got val=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                     t, cyc, w_valid, w_idx, w_data, w_last, t, exp_w[0][t], t == 63);
         end
         rdy = ($urandom_range(0, 99) >= 40);
         if ((t == 0 || t == 63) && held < 2) rdy = 1'b0;
         w_ready = rdy;
         if (rdy) begin
            t++;
            held = 0;
         end else begin
            held++;
         end
         cyc++;
         @(negedge clk);
      end
      w_ready = 1'b1;
      checks++;
      if ({blk_ready, w_valid} !== 2'b10) begin
         errors++;
         $display("FAIL bp_done: got rdy=%b val=%b, want 1 0", blk_ready, w_valid);
      end
   endtask

   task automatic test_back_to_back();
      blk_data = blk_a;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      @(negedge clk);
      blk_data = blk_b;
      for (int t = 0; t < 64; t++) begin
         checks++;
         if ({w_valid, blk_ready, w_idx, w_data} !== {1'b1, 1'b0, 6'(t), exp_w[0][t]}) begin
            errors++;
            $display("FAIL b2b_first t=%0d: got val=%b rdy=%b idx=%0d data=%h, want 1 0 %0d %h",
                     t, w_valid, blk_ready, w_idx, w_data, t, exp_w[0][t]);
         end
         @(negedge clk);
      end
      checks++;
      if ({blk_ready, w_valid} !== 2'b10) begin
         errors++;
         $display("FAIL b2b_accept: got rdy=%b val=%b, want 1 0", blk_ready, w_valid);
      end
      @(negedge clk);
      blk_valid = 1'b0;
      for (int t = 0; t < 64; t++) begin
         checks++;
         if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 6'(t), exp_w[1][t], t == 63}) begin
            errors++;
            $display("FAIL b2b_second t=%0d: got val=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                     t, w_valid, w_idx, w_data, w_last, t, exp_w[1][t], t == 63);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      blk_data = blk_a;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if ({w_valid, w_idx, w_data} !== {1'b1, 6'd30, exp_w[0][30]}) begin
         errors++;
         $display("FAIL rstmid_t30: got val=%b idx=%0d data=%h, want 1 30 %h",
                  w_valid, w_idx, w_data, exp_w[0][30]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({blk_ready, w_valid, w_data, w_idx, w_last} !== {1'b1, 1'b0, 32'h0, 6'h0, 1'b0}) begin
         errors++;
         $display("FAIL rstmid_async: got rdy=%b val=%b data=%h idx=%0d last=%b, want 1 0 0 0 0",
                  blk_ready, w_valid, w_data, w_idx, w_last);
      end
      @(negedge clk);
      rst = 1'b0;
      blk_data = blk_b;
      blk_valid = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      checks++;
      if ({w_valid, w_idx, w_data} !== {1'b1, 6'd0, exp_w[1][0]}) begin
         errors++;
         $display("FAIL rstmid_new_w0: got val=%b idx=%0d data=%h, want 1 0 %h",
                  w_valid, w_idx, w_data, exp_w[1][0]);
      end
      repeat (64) @(negedge clk);
      checks++;
      if ({blk_ready, w_valid} !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_done: got rdy=%b val=%b, want 1 0", blk_ready, w_valid);
      end
   endtask

`ifdef SHA256_SCHED_ABORT_EN
   task automatic test_abort();
      abort = 1'b1;
      #1;
      checks++;
      if (blk_ready !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle_ready: got %b want 0", blk_ready);
      end
      abort = 1'b0;
      blk_data = blk_a;
      blk_valid = 1'b1;
      w_ready = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      repeat (20) @(negedge clk);
      abort = 1'b1;
      blk_data = blk_b;
      blk_valid = 1'b1;
      #1;
      checks++;
      if ({w_idx, blk_ready} !== {6'd20, 1'b0}) begin
         errors++;
         $display("FAIL abort_cycle: got idx=%0d rdy=%b, want 20 0", w_idx, blk_ready);
      end
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({w_valid, blk_ready, w_idx, w_last} !== {1'b0, 1'b1, 6'd0, 1'b0}) begin
         errors++;
         $display("FAIL abort_next: got val=%b rdy=%b idx=%0d last=%b, want 0 1 0 0",
                  w_valid, blk_ready, w_idx, w_last);
      end
      @(negedge clk);
      blk_valid = 1'b0;
      for (int t = 0; t < 64; t++) begin
         checks++;
         if ({w_valid, w_idx, w_data, w_last} !== {1'b1, 6'(t), exp_w[1][t], t == 63}) begin
            errors++;
            $display("FAIL abort_after t=%0d: got val=%b idx=%0d data=%h last=%b, want 1 %0d %h %b",
                     t, w_valid, w_idx, w_data, w_last, t, exp_w[1][t], t == 63);
         end
         @(negedge clk);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
`ifdef SHA256_SCHED_ABORT_EN
      abort = 1'b0;
`endif
      blk_a = {32'h61626380, 448'h0, 32'h00000018};
      for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h0123_4567 ^ (32'h1111_1111 * i);
      expand(0, blk_a);
      expand(1, blk_b);

      test_reset();
      test_abc();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef SHA256_SCHED_ABORT_EN
      test_abort();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
